// File: rtl/ram_burst_ctrl_if.sv
// Requester-side bus of the main-memory back end.
// Byte address in, per-beat read/write strobes and last flag out.
interface ram_burst_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BUS_W = 18
);
  logic [ADDR_BUS_W-1:0] mem_addr;
  logic                  mem_enable;
  logic                  mem_rw;
  logic                  mem_op_size;
  logic                  mem_finishes_op;
  logic [DATA_WIDTH-1:0] mem_write;
  logic                  mem_write_req;
  logic [DATA_WIDTH-1:0] mem_read;
  logic                  mem_read_valid;
  logic                  mem_last;
  logic                  busy;

  modport master (
    output mem_addr, mem_enable, mem_rw,
    output mem_op_size, mem_finishes_op,
    output mem_write,
    input  mem_write_req, mem_read,
    input  mem_read_valid, mem_last, busy
  );

  modport slave (
    input  mem_addr, mem_enable, mem_rw,
    input  mem_op_size, mem_finishes_op,
    input  mem_write,
    output mem_write_req, mem_read,
    output mem_read_valid, mem_last, busy
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Single-port word RAM serving one line burst or single word at a time.
// Reads stream one word per cycle after a one-cycle issue slot.
module ram_burst_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter     INIT_FILE  = ""
) (
  input logic clk,
  input logic rst,
  ram_burst_ctrl_if.slave bus
);
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_BURST = CW'(BURST_LEN - 1);
  localparam logic MEM_READ = 1'b0;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RD_ISSUE  = 2'd1;
  localparam logic [1:0] RD_STREAM = 2'd2;
  localparam logic [1:0] WRITE     = 2'd3;

  logic [DATA_WIDTH-1:0] ram [0:(2**ADDR_WIDTH)-1];

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  single_q, single_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  re;
  logic                  rd_valid;
  logic                  wr_req;
  logic                  is_final;
  logic                  last;
  logic                  unused_addr;

  assign unused_addr = ^bus.mem_addr[1:0];

  always_comb begin
    beat_addr = base_q + {{(ADDR_WIDTH-CW){1'b0}}, cnt_q};
    is_final  = single_q ? (cnt_q == '0)
                         : (cnt_q == LAST_BURST);
    rd_valid  = (state_q == RD_STREAM) & bus.mem_enable;
    wr_req    = (state_q == WRITE) & bus.mem_enable;
    last      = (rd_valid | wr_req)
              & (is_final | bus.mem_finishes_op);
  end

  // Only touch the read register when a word is really needed,
  // so mem_read holds its value across idle and abort cycles.
  always_comb begin
    re    = 1'b0;
    raddr = beat_addr;
    case (state_q)
      RD_ISSUE: begin
        re    = bus.mem_enable;
        raddr = base_q;
      end
      RD_STREAM: begin
        re    = rd_valid & ~last;
        raddr = beat_addr + ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    single_d = single_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_enable) begin
          base_d   = bus.mem_addr[ADDR_WIDTH+1:2];
          single_d = bus.mem_op_size;
          cnt_d    = '0;
          state_d  = (bus.mem_rw == MEM_READ) ? RD_ISSUE
                                              : WRITE;
        end
      end
      RD_ISSUE: begin
        state_d = bus.mem_enable ? RD_STREAM : IDLE;
      end
      RD_STREAM, WRITE: begin
        if (!bus.mem_enable || last)
          state_d = IDLE;
        else
          cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      single_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      single_q <= single_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data_q <= '0;
    else if (re)
      rd_data_q <= ram[raddr];
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_req)
      ram[beat_addr] <= bus.mem_write;
  end

  assign bus.mem_read       = rd_data_q;
  assign bus.mem_read_valid = rd_valid;
  assign bus.mem_write_req  = wr_req;
  assign bus.mem_last       = last;
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl: bursts, singles, wrap,
// early finish, abort and mid-burst reset.
module tb_ram_burst_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ram_burst_ctrl_if #(.DATA_WIDTH(32), .ADDR_BUS_W(18)) bus();

  ram_burst_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .BURST_LEN(8),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start(input logic rw, input logic [17:0] addr,
                       input logic single);
    @(negedge clk);
    bus.mem_enable      = 1'b1;
    bus.mem_rw          = rw;
    bus.mem_addr        = addr;
    bus.mem_op_size     = single;
    bus.mem_finishes_op = 1'b0;
  endtask

  task automatic rd_burst(input logic [17:0] addr, input logic single,
                          input int n, input logic [31:0] base,
                          input int fin);
    start(1'b0, addr, single);
    @(negedge clk);
    bus.mem_addr = 18'h3_0000;
    bus.mem_rw   = 1'b1;
    #1;
    chk("rd_issue_valid", 32'(bus.mem_read_valid), 32'd0);
    chk("rd_issue_busy", 32'(bus.busy), 32'd1);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      bus.mem_finishes_op = (b == fin);
      #1;
      chk("rd_valid", 32'(bus.mem_read_valid), 32'd1);
      chk("rd_data", bus.mem_read, base + 32'(b));
      chk("rd_last", 32'(bus.mem_last), 32'(b == n - 1));
    end
    @(negedge clk);
    bus.mem_enable      = 1'b0;
    bus.mem_finishes_op = 1'b0;
    #1;
    chk("rd_done_busy", 32'(bus.busy), 32'd0);
    chk("rd_done_valid", 32'(bus.mem_read_valid), 32'd0);
    chk("rd_hold", bus.mem_read, base + 32'(n - 1));
  endtask

  task automatic wr_burst(input logic [17:0] addr, input logic single,
                          input int n, input logic [31:0] base,
                          input int abort_at);
    start(1'b1, addr, single);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      if (b == abort_at) begin
        bus.mem_enable = 1'b0;
        #1;
        chk("wr_abort_req", 32'(bus.mem_write_req), 32'd0);
        chk("wr_abort_last", 32'(bus.mem_last), 32'd0);
        break;
      end
      bus.mem_write = base + 32'(b);
      if (b == 1) bus.mem_addr = 18'h0;
      #1;
      chk("wr_req", 32'(bus.mem_write_req), 32'd1);
      chk("wr_last", 32'(bus.mem_last), 32'(b == n - 1));
    end
    @(negedge clk);
    bus.mem_enable = 1'b0;
    bus.mem_write  = 32'hFFFF_FFFF;
    #1;
    chk("wr_done_busy", 32'(bus.busy), 32'd0);
    chk("wr_done_req", 32'(bus.mem_write_req), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_addr        = '0;
    bus.mem_enable      = 1'b0;
    bus.mem_rw          = 1'b0;
    bus.mem_op_size     = 1'b0;
    bus.mem_finishes_op = 1'b0;
    bus.mem_write       = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_read", bus.mem_read, 32'd0);
    chk("rst_valid", 32'(bus.mem_read_valid), 32'd0);
    chk("rst_req", 32'(bus.mem_write_req), 32'd0);
    chk("rst_last", 32'(bus.mem_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    // line burst read of a preloaded line
    wr_burst(18'h40, 1'b0, 8, 32'hA0, -1);
    rd_burst(18'h40, 1'b0, 8, 32'hA0, -1);

    // write burst and read back
    wr_burst(18'h80, 1'b0, 8, 32'd1, -1);
    rd_burst(18'h80, 1'b0, 8, 32'd1, -1);

    // single word write and read
    wr_burst(18'h4, 1'b1, 1, 32'hDEAD_BEEF, -1);
    rd_burst(18'h4, 1'b1, 1, 32'hDEAD_BEEF, -1);

    // bursts wrapping past the top word into words 0..3
    wr_burst(18'h3_FFF0, 1'b0, 8, 32'hC0, -1);
    rd_burst(18'h3_FFF0, 1'b0, 8, 32'hC0, -1);
    rd_burst(18'h0, 1'b1, 1, 32'hC4, -1);

    // early finish on beat 3
    rd_burst(18'h40, 1'b0, 3, 32'hA0, 2);

    // abort a write after three beats
    wr_burst(18'h0, 1'b0, 8, 32'hE0, 3);
    rd_burst(18'h0, 1'b1, 1, 32'hE0, -1);
    rd_burst(18'h4, 1'b1, 1, 32'hE1, -1);
    rd_burst(18'h8, 1'b1, 1, 32'hE2, -1);
    rd_burst(18'hC, 1'b1, 1, 32'hC7, -1);

    // reset on the 4th beat of a read burst
    start(1'b0, 18'h40, 1'b0);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      #1;
      chk("rst_mid_valid", 32'(bus.mem_read_valid), 32'd1);
      chk("rst_mid_data", bus.mem_read, 32'hA0 + 32'(b));
      if (b == 3) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_enable = 1'b0;
    #1;
    chk("rst2_read", bus.mem_read, 32'd0);
    chk("rst2_valid", 32'(bus.mem_read_valid), 32'd0);
    chk("rst2_req", 32'(bus.mem_write_req), 32'd0);
    chk("rst2_last", 32'(bus.mem_last), 32'd0);
    chk("rst2_busy", 32'(bus.busy), 32'd0);
    rd_burst(18'h40, 1'b0, 8, 32'hA0, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
